// File: rtl/legv8_ctrl_pkg.sv
// Shared LEGv8 control definitions: opcodes, ALU function-select codes,
// the control-word layout and the sequencer state encoding.
package legv8_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_NOP    = 5'b00000,
    OP_ADD    = 5'b00001,
    OP_SUB    = 5'b00010,
    OP_AND    = 5'b00011,
    OP_ORR    = 5'b00100,
    OP_EOR    = 5'b00101,
    OP_ADDI   = 5'b00110,
    OP_SUBI   = 5'b00111,
    OP_ADDS   = 5'b01000,
    OP_SUBS   = 5'b01001,
    OP_CMP    = 5'b01010,
    OP_MOV    = 5'b01011,
    OP_MOVI   = 5'b01100,
    OP_LSL    = 5'b01101,
    OP_CLRALL = 5'b01110
  } opcode_e;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;

  localparam logic [4:0] XZR_IDX      = 5'd31;
  // Highest register cleared by CLRALL; r31 is the zero register.
  localparam logic [4:0] CLR_LAST_IDX = 5'd30;

  typedef struct packed {
    logic        w;
    logic        en_alu;
    logic        en_b;
    logic        k_sel;
    logic        c0;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [63:0] k;
  } cw_t;

  localparam cw_t CW_IDLE = '0;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } state_e;

  function automatic cw_t alu_word(input logic [4:0] rd,
                                   input logic [4:0] rn,
                                   input logic [4:0] rm,
                                   input logic [4:0] fs,
                                   input logic       c0);
    cw_t cw;
    cw        = CW_IDLE;
    cw.w      = 1'b1;
    cw.en_alu = 1'b1;
    cw.sa     = rn;
    cw.sb     = rm;
    cw.da     = rd;
    cw.fs     = fs;
    cw.c0     = c0;
    return cw;
  endfunction

  // CLRALL writes (0 AND K=0) into one register per cycle.
  function automatic cw_t clr_word(input logic [4:0] da);
    cw_t cw;
    cw        = CW_IDLE;
    cw.w      = 1'b1;
    cw.en_alu = 1'b1;
    cw.k_sel  = 1'b1;
    cw.k      = 64'd0;
    cw.fs     = FS_AND;
    cw.da     = da;
    return cw;
  endfunction

endpackage

// File: rtl/cw_decode.sv
// Combinational instruction decoder: instruction word -> control word plus
// flag-capture, illegal-opcode and CLRALL indications.
module cw_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output cw_t         o_cw,
  output logic        o_flag_set,
  output logic        o_illegal,
  output logic        o_clrall
);

  logic [4:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_rn;
  logic [4:0]  w_rm;
  logic [11:0] w_imm;

  assign w_op  = instr[31:27];
  assign w_rd  = instr[26:22];
  assign w_rn  = instr[21:17];
  assign w_rm  = instr[16:12];
  assign w_imm = instr[11:0];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_cw       = CW_IDLE;
    o_flag_set = 1'b0;
    o_illegal  = 1'b0;
    o_clrall   = 1'b0;
    case (w_op)
      OP_NOP: o_cw = CW_IDLE;
      OP_ADD: o_cw = alu_word(w_rd, w_rn, w_rm, FS_ADD, 1'b0);
      OP_SUB: o_cw = alu_word(w_rd, w_rn, w_rm, FS_SUB, 1'b1);
      OP_AND: o_cw = alu_word(w_rd, w_rn, w_rm, FS_AND, 1'b0);
      OP_ORR: o_cw = alu_word(w_rd, w_rn, w_rm, FS_ORR, 1'b0);
      OP_EOR: o_cw = alu_word(w_rd, w_rn, w_rm, FS_EOR, 1'b0);
      OP_ADDI: begin
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_ADD, 1'b0);
        o_cw.k_sel = 1'b1;
        o_cw.k     = {52'd0, w_imm};
      end
      OP_SUBI: begin
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_SUB, 1'b1);
        o_cw.k_sel = 1'b1;
        o_cw.k     = {52'd0, w_imm};
      end
      OP_ADDS: begin
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_ADD, 1'b0);
        o_flag_set = 1'b1;
      end
      OP_SUBS: begin
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_SUB, 1'b1);
        o_flag_set = 1'b1;
      end
      OP_CMP: begin
        // Compare is a SUBS whose result is discarded.
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_SUB, 1'b1);
        o_cw.w     = 1'b0;
        o_flag_set = 1'b1;
      end
      OP_MOV: begin
        o_cw.w    = 1'b1;
        o_cw.en_b = 1'b1;
        o_cw.sb   = w_rm;
        o_cw.da   = w_rd;
      end
      OP_MOVI: begin
        o_cw       = alu_word(w_rd, XZR_IDX, w_rm, FS_ORR, 1'b0);
        o_cw.k_sel = 1'b1;
        o_cw.k     = {52'd0, w_imm};
      end
      OP_LSL: begin
        o_cw       = alu_word(w_rd, w_rn, w_rm, FS_LSL, 1'b0);
        o_cw.k_sel = 1'b1;
        o_cw.k     = {58'd0, w_imm[5:0]};
      end
      OP_CLRALL: o_clrall = 1'b1;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_word_sequencer.sv
// LEGv8 control-word sequencer: issues one decoded instruction per cycle and
// expands CLRALL into a 31-cycle register-clearing sequence (r0..r30).
module control_word_sequencer
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        W,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        K_SEL,
  output logic        C0,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [4:0]  FS,
  output logic [63:0] K,
  input  logic [3:0]  status_in,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        illegal
);

  cw_t        w_dec_cw;
  logic       w_dec_flag_set;
  logic       w_dec_illegal;
  logic       w_dec_clrall;
  logic       w_accept;

  state_e     r_state;
  state_e     w_state_next;
  logic [4:0] r_count;
  logic [4:0] w_count_next;
  cw_t        r_cw;
  cw_t        w_cw_next;
  logic       r_flag_set;
  logic       w_flag_set_next;
  logic [3:0] r_flags;
  logic       r_illegal;
  logic       r_in_ready;

  cw_decode u_cw_decode (
    .instr      (instr),
    .o_cw       (w_dec_cw),
    .o_flag_set (w_dec_flag_set),
    .o_illegal  (w_dec_illegal),
    .o_clrall   (w_dec_clrall)
  );

  // r_in_ready is low through reset and during CLR, so acceptance implies RUN.
  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_cw_next       = CW_IDLE;
    w_flag_set_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (w_dec_clrall) begin
            w_state_next = ST_CLR;
            w_count_next = 5'd0;
            w_cw_next    = clr_word(5'd0);
          end else begin
            w_cw_next       = w_dec_cw;
            w_flag_set_next = w_dec_flag_set;
          end
        end
      end
      ST_CLR: begin
        // Counter saturates at r30 and hands control back to RUN.
        if (r_count == CLR_LAST_IDX) begin
          w_state_next = ST_RUN;
        end else begin
          w_count_next = r_count + 5'd1;
          w_cw_next    = clr_word(r_count + 5'd1);
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_count    <= 5'd0;
      r_cw       <= CW_IDLE;
      r_flag_set <= 1'b0;
      r_flags    <= 4'd0;
      r_illegal  <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_cw       <= w_cw_next;
      r_flag_set <= w_flag_set_next;
      r_in_ready <= (w_state_next == ST_RUN);
      if (r_flag_set) begin
        r_flags <= status_in;
      end
      if (w_accept && w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign W        = r_cw.w;
  assign EN_ALU   = r_cw.en_alu;
  assign EN_B     = r_cw.en_b;
  assign K_SEL    = r_cw.k_sel;
  assign C0       = r_cw.c0;
  assign SA       = r_cw.sa;
  assign SB       = r_cw.sb;
  assign DA       = r_cw.da;
  assign FS       = r_cw.fs;
  assign K        = r_cw.k;
  assign flags    = r_flags;
  assign illegal  = r_illegal;
  assign busy     = (r_state == ST_CLR);
  assign in_ready = r_in_ready;

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed self-checking bench for control_word_sequencer.
module tb_control_word_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        W, EN_ALU, EN_B, K_SEL, C0;
  logic [4:0]  SA, SB, DA, FS;
  logic [63:0] K;
  logic [3:0]  status_in;
  logic [3:0]  flags;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [88:0] obs;
  assign obs = {W, EN_ALU, EN_B, K_SEL, C0, SA, SB, DA, FS, K};

  localparam logic [88:0] IDLE = '0;

  control_word_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .W         (W),
    .EN_ALU    (EN_ALU),
    .EN_B      (EN_B),
    .K_SEL     (K_SEL),
    .C0        (C0),
    .SA        (SA),
    .SB        (SB),
    .DA        (DA),
    .FS        (FS),
    .K         (K),
    .status_in (status_in),
    .flags     (flags),
    .busy      (busy),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rn, input logic [4:0] rm,
                                      input logic [11:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  function automatic logic [88:0] cw(input logic w, input logic alu, input logic b,
                                     input logic ksel, input logic c0,
                                     input logic [4:0] sa, input logic [4:0] sb,
                                     input logic [4:0] da, input logic [4:0] fs,
                                     input logic [63:0] k);
    return {w, alu, b, ksel, c0, sa, sb, da, fs, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    instr = enc(5'b00001, 5'd1, 5'd2, 5'd3, 12'd0);
    status_in = 4'b1111;
    repeat (2) tick();
    n_checks++;
    if (obs !== IDLE) begin
      n_fail++; $display("FAIL reset_word: got %h expected %h", obs, IDLE);
    end
    n_checks++;
    if ({flags, illegal, busy, in_ready} !== 7'd0) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0000000", {flags, illegal, busy, in_ready});
    end
    in_valid = 1'b0;
    status_in = 4'b0000;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: in_ready/busy got %b expected 10", {in_ready, busy});
    end
  endtask

  task automatic test_addi();
    in_valid = 1'b1;
    instr = enc(5'b00110, 5'd2, 5'd1, 5'd0, 12'd5);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== cw(1, 1, 0, 1, 0, 5'd1, 5'd0, 5'd2, 5'b01000, 64'd5)) begin
      n_fail++; $display("FAIL addi_word: got %h expected %h", obs,
                         cw(1, 1, 0, 1, 0, 5'd1, 5'd0, 5'd2, 5'b01000, 64'd5));
    end
    tick();
    n_checks++;
    if (obs !== IDLE) begin
      n_fail++; $display("FAIL addi_idle_after: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] vi[11];
    logic [88:0] ve[11];
    vi[0]  = enc(5'b00001, 5'd1,  5'd2,  5'd3,  12'h7FF);
    ve[0]  = cw(1, 1, 0, 0, 0, 5'd2,  5'd3,  5'd1,  5'b01000, 64'd0);
    vi[1]  = enc(5'b00010, 5'd4,  5'd5,  5'd6,  12'd0);
    ve[1]  = cw(1, 1, 0, 0, 1, 5'd5,  5'd6,  5'd4,  5'b01001, 64'd0);
    vi[2]  = enc(5'b00011, 5'd7,  5'd8,  5'd9,  12'd0);
    ve[2]  = cw(1, 1, 0, 0, 0, 5'd8,  5'd9,  5'd7,  5'b00000, 64'd0);
    vi[3]  = enc(5'b00100, 5'd10, 5'd11, 5'd12, 12'd0);
    ve[3]  = cw(1, 1, 0, 0, 0, 5'd11, 5'd12, 5'd10, 5'b00100, 64'd0);
    vi[4]  = enc(5'b00101, 5'd13, 5'd14, 5'd15, 12'd0);
    ve[4]  = cw(1, 1, 0, 0, 0, 5'd14, 5'd15, 5'd13, 5'b01100, 64'd0);
    vi[5]  = enc(5'b00111, 5'd16, 5'd17, 5'd18, 12'hFFF);
    ve[5]  = cw(1, 1, 0, 1, 1, 5'd17, 5'd18, 5'd16, 5'b01001, 64'hFFF);
    vi[6]  = enc(5'b01101, 5'd19, 5'd20, 5'd21, 12'hABC);
    ve[6]  = cw(1, 1, 0, 1, 0, 5'd20, 5'd21, 5'd19, 5'b10000, 64'h3C);
    vi[7]  = enc(5'b01100, 5'd22, 5'd23, 5'd24, 12'h123);
    ve[7]  = cw(1, 1, 0, 1, 0, 5'd31, 5'd24, 5'd22, 5'b00100, 64'h123);
    vi[8]  = enc(5'b01000, 5'd25, 5'd26, 5'd27, 12'd0);
    ve[8]  = cw(1, 1, 0, 0, 0, 5'd26, 5'd27, 5'd25, 5'b01000, 64'd0);
    vi[9]  = enc(5'b01001, 5'd28, 5'd29, 5'd30, 12'd0);
    ve[9]  = cw(1, 1, 0, 0, 1, 5'd29, 5'd30, 5'd28, 5'b01001, 64'd0);
    vi[10] = enc(5'b00000, 5'd5,  5'd6,  5'd7,  12'hFFF);
    ve[10] = IDLE;
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      instr = vi[i];
      tick();
      n_checks++;
      if (obs !== ve[i]) begin
        n_fail++; $display("FAIL alu_op[%0d] op=%b: got %h expected %h", i, vi[i][31:27], obs, ve[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL alu_ops_illegal: got %b expected 0", illegal);
    end
  endtask

  task automatic test_mov();
    in_valid = 1'b1;
    instr = enc(5'b01011, 5'd7, 5'd5, 5'd6, 12'd0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({EN_B, EN_ALU, SB, DA, W} !== {1'b1, 1'b0, 5'd6, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL mov_word: EN_B/EN_ALU/SB/DA/W got %b %b %0d %0d %b expected 1 0 6 7 1",
                         EN_B, EN_ALU, SB, DA, W);
    end
  endtask

  task automatic test_cmp_flags();
    status_in = 4'b0101;
    in_valid = 1'b1;
    instr = enc(5'b01010, 5'd9, 5'd3, 5'd4, 12'd0);
    tick();
    n_checks++;
    if (obs !== cw(0, 1, 0, 0, 1, 5'd3, 5'd4, 5'd9, 5'b01001, 64'd0)) begin
      n_fail++; $display("FAIL cmp_word: got %h expected %h", obs,
                         cw(0, 1, 0, 0, 1, 5'd3, 5'd4, 5'd9, 5'b01001, 64'd0));
    end
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++; $display("FAIL cmp_flags_early: got %b expected 0000", flags);
    end
    instr = enc(5'b00001, 5'd1, 5'd2, 5'd3, 12'd0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (flags !== 4'b0101) begin
      n_fail++; $display("FAIL cmp_flags_captured: got %b expected 0101", flags);
    end
    status_in = 4'b1010;
    tick();
    n_checks++;
    if (flags !== 4'b0101) begin
      n_fail++; $display("FAIL add_flags_hold: got %b expected 0101", flags);
    end
    in_valid = 1'b1;
    instr = enc(5'b01000, 5'd1, 5'd2, 5'd3, 12'd0);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (flags !== 4'b1010) begin
      n_fail++; $display("FAIL adds_flags_captured: got %b expected 1010", flags);
    end
    status_in = 4'b0000;
  endtask

  task automatic test_clrall();
    in_valid = 1'b1;
    instr = enc(5'b01110, 5'd0, 5'd0, 5'd0, 12'd0);
    tick();
    instr = enc(5'b00001, 5'd5, 5'd1, 5'd2, 12'd0);
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) tick();
      n_checks++;
      if ({W, EN_ALU, EN_B, K_SEL, K, FS, DA, busy, in_ready} !==
          {1'b1, 1'b1, 1'b0, 1'b1, 64'd0, 5'd0, 5'(i), 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL clrall_step[%0d]: W/ALU/B/KSEL=%b%b%b%b K=%h FS=%b DA=%0d busy=%b rdy=%b expected DA=%0d 1101 K=0 FS=0 busy=1 rdy=0",
                           i, W, EN_ALU, EN_B, K_SEL, K, FS, DA, busy, in_ready, i);
      end
    end
    tick();
    n_checks++;
    if ({obs, busy, in_ready} !== {IDLE, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL clrall_end: word %h busy=%b rdy=%b expected idle busy=0 rdy=1", obs, busy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== cw(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd5, 5'b01000, 64'd0)) begin
      n_fail++; $display("FAIL clrall_next_add: got %h expected %h", obs,
                         cw(1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd5, 5'b01000, 64'd0));
    end
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL clrall_illegal: got %b expected 0", illegal);
    end
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1;
    instr = enc(5'b01110, 5'd0, 5'd0, 5'd0, 12'd0);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    n_checks++;
    if ({DA, busy} !== {5'd9, 1'b1}) begin
      n_fail++; $display("FAIL abort_pre: DA=%0d busy=%b expected DA=9 busy=1", DA, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({obs, busy, in_ready, flags, illegal} !== {IDLE, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL abort_async: word %h busy=%b rdy=%b flags=%b ill=%b expected idle 0 0 0000 0",
                         obs, busy, in_ready, flags, illegal);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({obs, busy, in_ready} !== {IDLE, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL abort_release: word %h busy=%b rdy=%b expected idle busy=0 rdy=1", obs, busy, in_ready);
    end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1;
    instr = enc(5'b01111, 5'd3, 5'd4, 5'd5, 12'h0FF);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({obs, illegal} !== {IDLE, 1'b1}) begin
      n_fail++; $display("FAIL illegal_01111: word %h ill=%b expected idle ill=1", obs, illegal);
    end
    do_reset();
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_cleared: got %b expected 0", illegal);
    end
    in_valid = 1'b1;
    instr = enc(5'b11111, 5'd3, 5'd4, 5'd5, 12'hFFF);
    tick();
    n_checks++;
    if ({obs, illegal} !== {IDLE, 1'b1}) begin
      n_fail++; $display("FAIL illegal_11111: word %h ill=%b expected idle ill=1", obs, illegal);
    end
    instr = enc(5'b00001, 5'd5, 5'd6, 5'd7, 12'd0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({obs, illegal} !== {cw(1, 1, 0, 0, 0, 5'd6, 5'd7, 5'd5, 5'b01000, 64'd0), 1'b1}) begin
      n_fail++; $display("FAIL illegal_then_add: word %h ill=%b expected add word ill=1", obs, illegal);
    end
    repeat (3) tick();
    n_checks++;
    if (illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky: got %b expected 1", illegal);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    status_in = '0;
    test_reset();
    test_addi();
    test_alu_ops();
    test_mov();
    test_cmp_flags();
    test_clrall();
    test_reset_abort();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_word_sequencer.md
CONTROL_WORD_SEQUENCER -- requirements
Module: control_word_sequencer

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst in 1 reset, asynchronous, active-low (0 = reset).
REQ-002 SHALL have: in_valid in 1 instruction offered; in_ready out 1 instruction accepted when in_valid&in_ready at a rising edge.
REQ-003 SHALL have: instr in 32, fields op=[31:27], rd=[26:22], rn=[21:17], rm=[16:12], imm12=[11:0].
REQ-004 SHALL have control-word outputs, all registered: W 1, EN_ALU 1, EN_B 1, K_SEL 1, C0 1, SA 5, SB 5, DA 5, FS 5, K 64.
REQ-005 SHALL have: status_in in 4 datapath Status (V,C,N,Z); flags out 4 captured flags; busy out 1 CLRALL in progress; illegal out 1 sticky illegal-opcode flag.

Function
REQ-006 SHALL be one instruction per cycle: instr accepted in cycle t drives its control word during cycle t+1; the register write completes at the end of t+1.
REQ-007 SHALL drive the idle word (W=0, EN_ALU=0, EN_B=0, K_SEL=0, C0=0, SA=SB=DA=FS=0, K=0) in any cycle with no instruction issued.
REQ-008 SHALL decode: NOP 00000 idle; ADD 00001 FS=01000; SUB 00010 FS=01001 C0=1; AND 00011 FS=00000; ORR 00100 FS=00100; EOR 00101 FS=01100.
REQ-009 SHALL decode: ADDI 00110 and SUBI 00111 as ADD/SUB with K_SEL=1 and K=zero-extended imm12.
REQ-010 SHALL decode: ADDS 01000 and SUBS 01001 as ADD/SUB plus flag capture; CMP 01010 as SUBS with W=0.
REQ-011 SHALL decode: MOV 01011 as EN_B=1, EN_ALU=0, SB=rm, W=1; MOVI 01100 as ORR with SA=31 (XZR), K_SEL=1, K=imm12.
REQ-012 SHALL decode: LSL 01101 as FS=10000, K_SEL=1, K=imm12[5:0] zero-extended.
REQ-013 SHALL, for every ALU-sourced op, drive EN_ALU=1, EN_B=0, SA=rn, SB=rm, DA=rd; W=1 except CMP.
REQ-014 SHALL never assert EN_ALU and EN_B in the same cycle.
REQ-015 SHALL treat opcodes 01111-11111 as NOP and set illegal=1 until reset.
REQ-016 SHALL load flags from status_in at the end of the cycle that carries an ADDS/SUBS/CMP control word; flags SHALL otherwise hold.
REQ-017 SHALL, for CLRALL 01110 accepted in cycle t:
  - drive W=1, EN_ALU=1, K_SEL=1, K=0, FS=00000, DA=0..30 in cycles t+1..t+31;
  - hold busy=1 and in_ready=0 during t+1..t+31;
  - drive in_ready=1 again at t+32.
REQ-018 SHALL hold in_ready=1 at all times outside CLRALL; in_valid is ignored while in_ready=0.
REQ-019 SHALL never write r31 during CLRALL; the counter stops at 30 with no wrap-around.
REQ-020 SHALL use a two-state FSM: RUN -> CLR on CLRALL acceptance; CLR -> RUN when the count equals 30.

Reset
REQ-021 SHALL, while rst=0 and regardless of clk: drive the idle word, set flags=0, illegal=0, busy=0, in_ready=0, state=RUN, count=0.
REQ-022 SHALL abort a CLRALL in progress on reset; the control word is idle from the reset assertion onward.
REQ-023 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-024 SHALL take opcodes, FS codes and the XZR index (31) from shared package legv8_ctrl_pkg.
REQ-025 SHALL contain one combinational sub-module, cw_decode (instr -> control word + flag-set/illegal/clrall indications); the FSM, counter and output registers stay in the top module.

Verification
REQ-026 SHALL cover ADDI rd=2, rn=1, imm=5 accepted at t -> at t+1: W=1, EN_ALU=1, K_SEL=1, K=5, FS=01000, SA=1, DA=2; at t+2 the word is idle.
REQ-027 SHALL cover CMP rn=3, rm=4 with status_in=4'b0101 -> W=0, FS=01001, C0=1; flags=0101 after the edge; a following ADD leaves flags at 0101.
REQ-028 SHALL cover MOV rd=7, rm=6 -> EN_B=1, EN_ALU=0, SB=6, DA=7, W=1.
REQ-029 SHALL cover CLRALL with in_valid held high on the next ADD -> DA steps 0..30 over 31 cycles, busy=1, in_ready=0; the ADD is accepted at t+32.
REQ-030 SHALL cover rst pulsed low at t+10 of CLRALL -> outputs go idle immediately; busy=0; in_ready=1 the cycle after release.
REQ-031 SHALL cover opcode 11111 -> idle word, illegal=1 until reset; subsequent legal ops still execute.
